id_ex_stage: RTL and testbench

//  ID/EX pipeline register downstream of the main opcode control decoder.

---
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register sitting behind the main opcode control decoder.
//   Captures the decoded control bundle and operands for EX, turns undefined
//   opcodes (whose decoder outputs float) into bubbles, inserts a one-cycle
//   bubble on load-use hazards, honours branch/jump flush and counts the
//   hazard/flush bubbles in a saturating counter.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   id_valid_i          ID holds a real instruction
//   id_opcode_i         instruction[6:0]
//   id_<ctrl>_i         decoder controls (branch, mem_read, memtoreg,
//                       mem_write, alu_src, reg_write, jal, jalr, alu_op)
//   id_<data>_i         pc, rs1/rs2 data, imm, rs1/rs2/rd, funct3, funct7b5
//   flush_i             branch/jump taken in EX: kill ID contents
//   ex_stall_i          downstream back-pressure: hold ID/EX
//   ex_valid_o          EX holds a real instruction
//   ex_<ctrl>_o/<data>_o registered copies of the ID inputs
//   ex_illegal_o        instruction dropped at the last load was illegal
//   stall_o             combinational: freeze PC and IF/ID this cycle
//   bubble_cnt_o        saturating count of hazard/flush bubbles
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic             id_branch_i,
  input  logic             id_mem_read_i,
  input  logic             id_memtoreg_i,
  input  logic             id_mem_write_i,
  input  logic             id_alu_src_i,
  input  logic             id_reg_write_i,
  input  logic             id_jal_i,
  input  logic             id_jalr_i,
  input  logic [1:0]       id_alu_op_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [2:0]       id_funct3_i,
  input  logic             id_funct7b5_i,
  input  logic             flush_i,
  input  logic             ex_stall_i,
  output logic             ex_valid_o,
  output logic             ex_branch_o,
  output logic             ex_mem_read_o,
  output logic             ex_memtoreg_o,
  output logic             ex_mem_write_o,
  output logic             ex_alu_src_o,
  output logic             ex_reg_write_o,
  output logic             ex_jal_o,
  output logic             ex_jalr_o,
  output logic [1:0]       ex_alu_op_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [2:0]       ex_funct3_o,
  output logic             ex_funct7b5_o,
  output logic             ex_illegal_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic            branch;
    logic            mem_read;
    logic            memtoreg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic            jal;
    logic            jalr;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } ex_bundle_t;

  ex_bundle_t       id_bundle;
  ex_bundle_t       ex_reg, ex_next;
  logic             valid_reg, valid_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_inc;
  logic             legal, uses_rs1, uses_rs2, load_use;

  assign id_bundle = '{
    branch:   id_branch_i,   mem_read:  id_mem_read_i,  memtoreg: id_memtoreg_i,
    mem_write: id_mem_write_i, alu_src: id_alu_src_i,   reg_write: id_reg_write_i,
    jal:      id_jal_i,      jalr:      id_jalr_i,      alu_op:   id_alu_op_i,
    pc:       id_pc_i,       rs1_data:  id_rs1_data_i,  rs2_data: id_rs2_data_i,
    imm:      id_imm_i,      rs1:       id_rs1_i,       rs2:      id_rs2_i,
    rd:       id_rd_i,       funct3:    id_funct3_i,    funct7b5: id_funct7b5_i
  };

  // Operand usage is derived from the opcode, not from decoder controls,
  // so an undefined opcode with floating controls can never raise a hazard.
  always_comb begin
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode_i)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
      7'b1101111:                         ;
      default:                            legal = 1'b0;
    endcase
  end

  assign load_use = valid_reg & ex_reg.mem_read & (ex_reg.rd != 5'd0) & id_valid_i &
                    ((uses_rs1 & (id_rs1_i == ex_reg.rd)) |
                     (uses_rs2 & (id_rs2_i == ex_reg.rd)));

  assign stall_o = ~flush_i & (load_use | ex_stall_i);

  always_comb begin
    ex_next      = ex_reg;
    valid_next   = valid_reg;
    illegal_next = 1'b0;
    cnt_inc      = 1'b0;
    if (flush_i) begin
      ex_next    = '0;
      valid_next = 1'b0;
      cnt_inc    = 1'b1;
    end else if (ex_stall_i) begin
      // hold everything
    end else if (load_use) begin
      ex_next    = '0;
      valid_next = 1'b0;
      cnt_inc    = 1'b1;
    end else if (id_valid_i && !legal) begin
      ex_next      = '0;
      valid_next   = 1'b0;
      illegal_next = 1'b1;
    end else if (!id_valid_i) begin
      ex_next    = '0;
      valid_next = 1'b0;
    end else begin
      ex_next    = id_bundle;
      valid_next = 1'b1;
    end
    cnt_next = (cnt_inc && (cnt_reg != {CNT_W{1'b1}})) ? cnt_reg + CNT_W'(1) : cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_reg      <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      ex_reg      <= ex_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign ex_valid_o     = valid_reg;
  assign ex_illegal_o   = illegal_reg;
  assign bubble_cnt_o   = cnt_reg;
  assign ex_branch_o    = ex_reg.branch;
  assign ex_mem_read_o  = ex_reg.mem_read;
  assign ex_memtoreg_o  = ex_reg.memtoreg;
  assign ex_mem_write_o = ex_reg.mem_write;
  assign ex_alu_src_o   = ex_reg.alu_src;
  assign ex_reg_write_o = ex_reg.reg_write;
  assign ex_jal_o       = ex_reg.jal;
  assign ex_jalr_o      = ex_reg.jalr;
  assign ex_alu_op_o    = ex_reg.alu_op;
  assign ex_pc_o        = ex_reg.pc;
  assign ex_rs1_data_o  = ex_reg.rs1_data;
  assign ex_rs2_data_o  = ex_reg.rs2_data;
  assign ex_imm_o       = ex_reg.imm;
  assign ex_rs1_o       = ex_reg.rs1;
  assign ex_rs2_o       = ex_reg.rs2;
  assign ex_rd_o        = ex_reg.rd;
  assign ex_funct3_o    = ex_reg.funct3;
  assign ex_funct7b5_o  = ex_reg.funct7b5;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, id_valid_i, flush_i, ex_stall_i;
  logic [6:0]  id_opcode_i;
  logic        id_branch_i, id_mem_read_i, id_memtoreg_i, id_mem_write_i;
  logic        id_alu_src_i, id_reg_write_i, id_jal_i, id_jalr_i;
  logic [1:0]  id_alu_op_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_funct3_i;
  logic        id_funct7b5_i;

  logic        ex_valid_o, ex_branch_o, ex_mem_read_o, ex_memtoreg_o, ex_mem_write_o;
  logic        ex_alu_src_o, ex_reg_write_o, ex_jal_o, ex_jalr_o, ex_illegal_o, stall_o;
  logic [1:0]  ex_alu_op_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o;
  logic [15:0] bubble_cnt_o;

  // Second instance with a narrow counter, driven identically, for saturation.
  logic        s_valid, s_branch, s_mem_read, s_memtoreg, s_mem_write;
  logic        s_alu_src, s_reg_write, s_jal, s_jalr, s_illegal, s_stall;
  logic [1:0]  s_alu_op;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_funct3;
  logic        s_funct7b5;
  logic [3:0]  s_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_branch_i(id_branch_i), .id_mem_read_i(id_mem_read_i), .id_memtoreg_i(id_memtoreg_i),
    .id_mem_write_i(id_mem_write_i), .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i),
    .id_jal_i(id_jal_i), .id_jalr_i(id_jalr_i), .id_alu_op_i(id_alu_op_i),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .ex_valid_o(ex_valid_o), .ex_branch_o(ex_branch_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_memtoreg_o(ex_memtoreg_o), .ex_mem_write_o(ex_mem_write_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_jal_o(ex_jal_o), .ex_jalr_o(ex_jalr_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct3_o(ex_funct3_o),
    .ex_funct7b5_o(ex_funct7b5_o), .ex_illegal_o(ex_illegal_o), .stall_o(stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_branch_i(id_branch_i), .id_mem_read_i(id_mem_read_i), .id_memtoreg_i(id_memtoreg_i),
    .id_mem_write_i(id_mem_write_i), .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i),
    .id_jal_i(id_jal_i), .id_jalr_i(id_jalr_i), .id_alu_op_i(id_alu_op_i),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .ex_valid_o(s_valid), .ex_branch_o(s_branch), .ex_mem_read_o(s_mem_read),
    .ex_memtoreg_o(s_memtoreg), .ex_mem_write_o(s_mem_write), .ex_alu_src_o(s_alu_src),
    .ex_reg_write_o(s_reg_write), .ex_jal_o(s_jal), .ex_jalr_o(s_jalr),
    .ex_alu_op_o(s_alu_op), .ex_pc_o(s_pc), .ex_rs1_data_o(s_rs1_data),
    .ex_rs2_data_o(s_rs2_data), .ex_imm_o(s_imm), .ex_rs1_o(s_rs1),
    .ex_rs2_o(s_rs2), .ex_rd_o(s_rd), .ex_funct3_o(s_funct3),
    .ex_funct7b5_o(s_funct7b5), .ex_illegal_o(s_illegal), .stall_o(s_stall),
    .bubble_cnt_o(s_cnt)
  );

  // Reference EX contents; ctrl = {branch,mem_read,memtoreg,mem_write,alu_src,reg_write,jal,jalr,alu_op}
  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [9:0]  ctrl;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  ex_t         m;
  int unsigned mcnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ex_t observed();
    return '{ex_valid_o, ex_illegal_o,
             {ex_branch_o, ex_mem_read_o, ex_memtoreg_o, ex_mem_write_o, ex_alu_src_o,
              ex_reg_write_o, ex_jal_o, ex_jalr_o, ex_alu_op_o},
             ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
             ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o};
  endfunction

  function automatic ex_t observed_sat();
    return '{s_valid, s_illegal,
             {s_branch, s_mem_read, s_memtoreg, s_mem_write, s_alu_src,
              s_reg_write, s_jal, s_jalr, s_alu_op},
             s_pc, s_rs1_data, s_rs2_data, s_imm, s_rs1, s_rs2, s_rd, s_funct3, s_funct7b5};
  endfunction

  function automatic bit op_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  function automatic bit op_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit op_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit model_hazard();
    return m.valid && m.ctrl[8] && (m.rd != 5'd0) && (id_valid_i === 1'b1) &&
           ((op_rs1(id_opcode_i) && id_rs1_i == m.rd) ||
            (op_rs2(id_opcode_i) && id_rs2_i == m.rd));
  endfunction

  // One clock: check stall_o, apply the priority rules to the model, check EX state.
  task automatic tick(input string tag);
    ex_t nm;
    bit  hz, st, cnt_up;
    #1;
    hz = model_hazard();
    st = !flush_i && (hz || ex_stall_i);
    check({tag, ":stall"}, 256'(stall_o), 256'(st));
    check({tag, ":stall_sat"}, 256'(s_stall), 256'(st));
    nm = m;
    nm.illegal = 1'b0;
    cnt_up = 1'b0;
    if (!rst_n) begin
      nm = '0;
    end else if (flush_i) begin
      nm = '0; cnt_up = 1'b1;
    end else if (ex_stall_i) begin
      // EX keeps its contents
    end else if (hz) begin
      nm = '0; cnt_up = 1'b1;
    end else if (id_valid_i && !op_legal(id_opcode_i)) begin
      nm = '0; nm.illegal = 1'b1;
    end else if (!id_valid_i) begin
      nm = '0;
    end else begin
      nm = '{1'b1, 1'b0,
             {id_branch_i, id_mem_read_i, id_memtoreg_i, id_mem_write_i, id_alu_src_i,
              id_reg_write_i, id_jal_i, id_jalr_i, id_alu_op_i},
             id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
             id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i};
    end
    @(posedge clk);
    m = nm;
    if (!rst_n) mcnt = 0;
    else if (cnt_up) mcnt++;
    #1;
    check({tag, ":ex"}, 256'(observed()), 256'(m));
    check({tag, ":ex_sat"}, 256'(observed_sat()), 256'(m));
    check({tag, ":cnt"}, 256'(bubble_cnt_o), 256'((mcnt > 65535) ? 65535 : mcnt));
    check({tag, ":cnt_sat"}, 256'(s_cnt), 256'((mcnt > 15) ? 15 : mcnt));
    $display("[TB] %-10s op=%b v=%b fl=%b st=%b -> ex_v=%b ill=%b cnt=%0d",
             tag, id_opcode_i, id_valid_i, flush_i, ex_stall_i, ex_valid_o, ex_illegal_o, bubble_cnt_o);
  endtask

  task automatic drive(input logic valid, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    id_valid_i  = valid;
    id_opcode_i = op;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
    id_funct3_i = 3'($urandom); id_funct7b5_i = 1'($urandom);
    if (op_legal(op) || !valid) begin
      {id_branch_i, id_mem_read_i, id_memtoreg_i, id_mem_write_i, id_alu_src_i,
       id_reg_write_i, id_jal_i, id_jalr_i, id_alu_op_i} = 10'($urandom);
      id_mem_read_i = (op == 7'b0000011);
    end else begin
      {id_branch_i, id_mem_read_i, id_memtoreg_i, id_mem_write_i, id_alu_src_i,
       id_reg_write_i, id_jal_i, id_jalr_i, id_alu_op_i} = 'z;
    end
  endtask

  task automatic drive_random();
    logic [6:0] ops [7];
    logic [6:0] op;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
    drive($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    flush_i    = ($urandom_range(0, 9) == 0);
    ex_stall_i = ($urandom_range(0, 6) == 0);
  endtask

  initial begin
    m = '0; mcnt = 0;
    rst_n = 1'b0; flush_i = 1'b0; ex_stall_i = 1'b0;
    drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;

    // Reset with random inputs, then quiet release
    for (int i = 0; i < 2; i++) begin drive_random(); tick("reset"); end
    check("reset:cnt0", 256'(bubble_cnt_o), 256'(0));
    rst_n = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0;
    drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0);
    #1 check("release:stall0", 256'(stall_o), 256'(0));
    tick("idle");

    // Pass-through: add x3,x1,x2 at pc 0x100
    drive(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd3);
    id_pc_i = 32'h100; id_alu_op_i = 2'b10; id_reg_write_i = 1'b1;
    tick("add");
    check("add:valid", 256'(ex_valid_o), 256'(1));
    check("add:alu_op", 256'(ex_alu_op_o), 256'(2'b10));
    check("add:pc", 256'(ex_pc_o), 256'(32'h100));

    // Load-use: lw x5; add x6,x5,x1 -> one bubble, then add enters
    drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5); tick("lw_x5");
    drive(1'b1, 7'b0110011, 5'd5, 5'd1, 5'd6);
    #1 check("lu:stall1", 256'(stall_o), 256'(1));
    tick("lu_bubble");
    check("lu:cnt1", 256'(bubble_cnt_o), 256'(1));
    check("lu:bubble", 256'(ex_valid_o), 256'(0));
    tick("lu_add");
    check("lu:add_in", 256'({ex_valid_o, ex_rd_o}), 256'({1'b1, 5'd6}));

    // rd = x0 never stalls
    drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0); tick("lw_x0");
    drive(1'b1, 7'b0110011, 5'd0, 5'd0, 5'd7); tick("use_x0");
    // store using x5 only as rs2 stalls, jal does not
    drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5); tick("lw_x5b");
    drive(1'b1, 7'b0100011, 5'd2, 5'd5, 5'd0); tick("sw_rs2");
    tick("sw_in");
    drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5); tick("lw_x5c");
    drive(1'b1, 7'b1101111, 5'd5, 5'd5, 5'd1); tick("jal");

    // Flush over a beq, then flush over a load-use
    drive(1'b1, 7'b1100011, 5'd1, 5'd2, 5'd0); flush_i = 1'b1; tick("flush_beq");
    flush_i = 1'b0;
    drive(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5); tick("lw_x5d");
    drive(1'b1, 7'b0110011, 5'd5, 5'd5, 5'd6); flush_i = 1'b1; tick("flush_lu");
    flush_i = 1'b0;

    // Illegal opcode with floating controls
    drive(1'b1, 7'b0000000, 5'd1, 5'd2, 5'd3); tick("illegal");
    check("illegal:flag", 256'(ex_illegal_o), 256'(1));
    drive(1'b1, 7'b0010011, 5'd1, 5'd2, 5'd3); tick("after_ill");

    // Hold for 3 cycles
    ex_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_random(); flush_i = 1'b0; ex_stall_i = 1'b1; tick("hold"); end
    ex_stall_i = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin drive_random(); tick("rand"); end

    // Enough flushes to saturate the narrow counter
    flush_i = 1'b0; ex_stall_i = 1'b0;
    for (int i = 0; i < 20; i++) begin drive_random(); flush_i = 1'b1; tick("sat"); end
    check("sat:cnt15", 256'(s_cnt), 256'(15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
